mc_hs_ctrl: RTL and testbench

MC_HS_CTRL -- requirements
Module: mc_hs_ctrl

---
 rtl/mc_pkg.sv | 30 +++
 rtl/mc_wait_timer.sv | 43 ++++
 rtl/mc_hs_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mc_hs_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the mc_hs_ctrl handshake controller.
// Holds the FSM state encoding (also exported on the debug state port),
// the instruction class codes driven on cls, and the halt cause codes on err.
package mc_pkg;

  typedef enum logic [2:0] {
    StIfReq  = 3'd0,
    StId     = 3'd1,
    StExe    = 3'd2,
    StMemReq = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } mc_state_e;

  localparam logic [2:0] ClsAlu    = 3'd0;
  localparam logic [2:0] ClsLoad   = 3'd1;
  localparam logic [2:0] ClsStore  = 3'd2;
  localparam logic [2:0] ClsBranch = 3'd3;  // redirect, no writeback
  localparam logic [2:0] ClsLink   = 3'd4;  // jump with writeback

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrIllegal = 2'd2;

  // Codes 5-7 are illegal classes.
  function automatic logic cls_legal(input logic [2:0] c);
    return c <= ClsLink;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Wait counter for a single memory handshake.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   clr         : restart the count (asserted on every FSM state change)
//   en          : the current cycle is a request cycle without ack
//   expired     : the count has reached TIMEOUT-1, so an un-acked cycle now
//                 is the TIMEOUT-th wait cycle and the handshake has failed
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] Last = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Last)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the register; the caller gates it with the missing ack,
  // so an ack on the last allowed cycle still wins.
  assign expired = (cnt_q == Last);

endmodule

// File: rtl/mc_hs_ctrl.sv
// Multi-cycle instruction sequencer with req/ack handshakes to instruction
// and data memories.
// Ports:
//   clk, resetn             : clock, synchronous active-low reset
//   inst_req/addr/ack/rdata : fetch handshake; inst_addr always equals pc
//   ir                      : latched instruction word
//   cls                     : externally decoded class of ir
//   br_taken, br_target     : redirect, sampled in EXE for BRANCH/LINK only
//   data_req/wr/ack         : data handshake for LOAD/STORE
//   pc                      : address of the instruction in flight
//   rf_we, retire           : one-cycle writeback and completion strobes
//   retired_cnt             : wrapping count of retire pulses
//   err, state              : sticky halt cause and debug state encoding
module mc_hs_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(32'h1c00_0000),
  parameter int unsigned         TIMEOUT  = 255,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ack,
  input  logic [31:0]       inst_rdata,
  output logic [31:0]       ir,
  input  logic [2:0]        cls,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              data_req,
  output logic              data_wr,
  input  logic              data_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              rf_we,
  output logic              retire,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [1:0]        err,
  output logic [2:0]        state
);

  mc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic timer_clr, timer_en, timer_expired;
  logic redirect;

  // Counter restarts on every state change, which covers entry to both
  // request states; it advances only on un-acked request cycles.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = ((state_q == StIfReq) && !inst_ack) ||
                     ((state_q == StMemReq) && !data_ack);

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  assign redirect = br_taken && ((cls == ClsBranch) || (cls == ClsLink));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;

    unique case (state_q)
      StIfReq: begin
        inst_req = 1'b1;
        if (inst_ack) begin
          ir_d    = inst_rdata;
          state_d = StId;
        end else if (timer_expired) begin
          err_d   = ErrTimeout;
          state_d = StHalt;
        end
      end

      StId: begin
        if (cls_legal(cls)) begin
          state_d = StExe;
        end else begin
          err_d   = ErrIllegal;
          state_d = StHalt;
        end
      end

      StExe: begin
        pc_d = redirect ? br_target : pc_q + ADDR_W'(4);
        unique case (cls)
          ClsLoad, ClsStore: state_d = StMemReq;
          ClsAlu, ClsLink:   state_d = StWb;
          ClsBranch: begin
            retire  = 1'b1;
            state_d = StIfReq;
          end
          default: begin
            // cls changed under a legal ir; treat as illegal
            pc_d    = pc_q;
            err_d   = ErrIllegal;
            state_d = StHalt;
          end
        endcase
      end

      StMemReq: begin
        data_req = 1'b1;
        data_wr  = (cls == ClsStore);
        if (data_ack) begin
          if (cls == ClsStore) begin
            retire  = 1'b1;
            state_d = StIfReq;
          end else begin
            state_d = StWb;
          end
        end else if (timer_expired) begin
          err_d   = ErrTimeout;
          state_d = StHalt;
        end
      end

      StWb: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = StIfReq;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StHalt;
      end
    endcase

    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Strobes are forced low while reset is held, before the edge that
    // samples it.
    if (!resetn) begin
      inst_req = 1'b0;
      data_req = 1'b0;
      data_wr  = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIfReq;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= ErrNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign err         = err_q;
  assign retired_cnt = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_hs_ctrl.sv
// Randomised bench for mc_hs_ctrl. Each instruction is described by its
// class, handshake delays and redirect; the expected strobe sequence, pc,
// retire count and halt cause follow from those with plain arithmetic.
module tb_mc_hs_ctrl;

  localparam int unsigned AW  = 32;
  localparam logic [31:0] RPC = 32'h1c00_0000;
  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;

  logic          clk, resetn;
  logic          inst_req, inst_ack, data_req, data_wr, data_ack;
  logic [AW-1:0] inst_addr, br_target, pc;
  logic [31:0]   inst_rdata, ir;
  logic [2:0]    cls, state;
  logic          br_taken, rf_we, retire;
  logic [CW-1:0] retired_cnt;
  logic [1:0]    err;

  mc_hs_ctrl #(
    .ADDR_W   (AW),
    .RESET_PC (RPC),
    .TIMEOUT  (TO),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_ack    (inst_ack),
    .inst_rdata  (inst_rdata),
    .ir          (ir),
    .cls         (cls),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_ack    (data_ack),
    .pc          (pc),
    .rf_we       (rf_we),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .err         (err),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  int          m_cnt;
  logic [1:0]  m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strobes(input string tag, input bit ireq, input bit dreq, input bit we,
                             input bit ret);
    check({tag, "_inst_req"}, 64'(inst_req), 64'(ireq));
    check({tag, "_data_req"}, 64'(data_req), 64'(dreq));
    check({tag, "_rf_we"},    64'(rf_we),    64'(we));
    check({tag, "_retire"},   64'(retire),   64'(ret));
  endtask

  task automatic chk_boundary(input string tag);
    check({tag, "_pc"},  64'(pc), 64'(m_pc));
    check({tag, "_cnt"}, 64'(retired_cnt), 64'(m_cnt % 16));
    check({tag, "_err"}, 64'(err), 64'(m_err));
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    inst_ack = 1'b1;
    data_ack = 1'b1;
    br_taken = 1'b0;
    #1;
    chk_strobes("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_data_wr", 64'(data_wr), 64'd0);
    tick();
    check("rst_pc", 64'(pc), 64'(RPC));
    check("rst_ir", 64'(ir), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cnt", 64'(retired_cnt), 64'd0);
    resetn   = 1'b1;
    inst_ack = 1'b0;
    data_ack = 1'b0;
    m_pc     = RPC;
    m_cnt    = 0;
    m_err    = 2'd0;
  endtask

  task automatic chk_halt();
    for (int i = 0; i < 3; i++) begin
      inst_ack = 1'($urandom);
      data_ack = 1'($urandom);
      #1;
      chk_strobes("halt", 1'b0, 1'b0, 1'b0, 1'b0);
      check("halt_err", 64'(err), 64'(m_err));
      check("halt_cnt", 64'(retired_cnt), 64'(m_cnt % 16));
      tick();
    end
  endtask

  // Runs one instruction. fd/dd are the number of un-acked request cycles
  // before the ack; a value >= TO means the handshake times out.
  task automatic run_instr(input logic [2:0] c, input int fd, input int dd, input bit tk,
                           input logic [31:0] tgt, input bit abort, output bit halted);
    logic [31:0] word;
    int          w;
    word   = $urandom;
    halted = 1'b0;
    // fetch
    w = 0;
    while (1) begin
      inst_ack   = (w == fd);
      inst_rdata = (w == fd) ? word : $urandom;
      cls        = 3'($urandom_range(0, 4));
      data_ack   = 1'($urandom);
      br_taken   = 1'($urandom);
      br_target  = $urandom;
      #1;
      chk_strobes("fetch", 1'b1, 1'b0, 1'b0, 1'b0);
      check("fetch_addr", 64'(inst_addr), 64'(m_pc));
      tick();
      if (w == fd) break;
      w++;
      if (w == int'(TO)) begin
        m_err    = 2'd1;
        halted   = 1'b1;
        inst_ack = 1'b0;
        return;
      end
    end
    // decode
    inst_ack = 1'($urandom);
    data_ack = 1'($urandom);
    cls      = c;
    #1;
    chk_strobes("id", 1'b0, 1'b0, 1'b0, 1'b0);
    check("ir", 64'(ir), 64'(word));
    tick();
    if (c >= 3'd5) begin
      m_err  = 2'd2;
      halted = 1'b1;
      return;
    end
    // execute
    br_taken  = tk;
    br_target = tgt;
    #1;
    chk_strobes("exe", 1'b0, 1'b0, 1'b0, c == 3'd3);
    tick();
    m_pc     = (tk && (c == 3'd3 || c == 3'd4)) ? tgt : m_pc + 32'd4;
    br_taken = 1'b0;
    if (c == 3'd3) begin
      m_cnt++;
      return;
    end
    // memory
    if (c == 3'd1 || c == 3'd2) begin
      if (abort) begin
        resetn   = 1'b0;
        data_ack = 1'b1;
        tick();
        resetn   = 1'b1;
        data_ack = 1'b0;
        #1;
        check("abort_data_req", 64'(data_req), 64'd0);
        check("abort_inst_req", 64'(inst_req), 64'd1);
        check("abort_pc", 64'(pc), 64'(RPC));
        check("abort_cnt", 64'(retired_cnt), 64'd0);
        m_pc  = RPC;
        m_cnt = 0;
        m_err = 2'd0;
        return;
      end
      w = 0;
      while (1) begin
        data_ack = (w == dd);
        inst_ack = 1'($urandom);
        #1;
        chk_strobes("mem", 1'b0, 1'b1, 1'b0, (w == dd) && (c == 3'd2));
        check("mem_data_wr", 64'(data_wr), 64'(c == 3'd2));
        tick();
        if (w == dd) break;
        w++;
        if (w == int'(TO)) begin
          m_err    = 2'd1;
          halted   = 1'b1;
          data_ack = 1'b0;
          return;
        end
      end
      data_ack = 1'b0;
      if (c == 3'd2) begin
        m_cnt++;
        return;
      end
    end
    // writeback
    inst_ack = 1'($urandom);
    data_ack = 1'($urandom);
    #1;
    chk_strobes("wb", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    m_cnt++;
  endtask

  task automatic step(input logic [2:0] c, input int fd, input int dd, input bit tk,
                      input logic [31:0] tgt, input bit abort);
    bit h;
    run_instr(c, fd, dd, tk, tgt, abort, h);
    if (h) begin
      chk_halt();
      do_reset();
    end else begin
      chk_boundary("ret");
    end
  endtask

  initial begin
    logic [2:0] c;
    int         fd, dd;
    resetn     = 1'b0;
    inst_ack   = 1'b0;
    data_ack   = 1'b0;
    inst_rdata = '0;
    cls        = '0;
    br_taken   = 1'b0;
    br_target  = '0;
    m_pc       = RPC;
    m_cnt      = 0;
    m_err      = 2'd0;
    tick();
    do_reset();

    step(3'd0, 0, 0, 1'b0, 32'h0, 1'b0);             // zero-wait ALU
    step(3'd1, 0, 3, 1'b0, 32'h0, 1'b0);             // load, 4-cycle data handshake
    step(3'd3, 0, 0, 1'b1, 32'h1c00_0100, 1'b0);     // taken branch
    step(3'd3, 1, 0, 1'b0, 32'h1c00_0200, 1'b0);     // not-taken branch
    step(3'd0, 0, 0, 1'b1, 32'hdead_bee0, 1'b0);     // br_taken ignored on ALU
    step(3'd4, 2, 0, 1'b1, 32'h1c00_0400, 1'b0);     // taken link
    step(3'd2, int'(TO) - 1, int'(TO) - 1, 1'b0, 32'h0, 1'b0);  // acks on last cycle
    step(3'd0, int'(TO), 0, 1'b0, 32'h0, 1'b0);      // fetch timeout
    step(3'd0, 0, 0, 1'b0, 32'h0, 1'b0);
    step(3'd6, 0, 0, 1'b0, 32'h0, 1'b0);             // illegal class
    step(3'd2, 0, int'(TO), 1'b0, 32'h0, 1'b0);      // data timeout
    step(3'd1, 0, 2, 1'b0, 32'h0, 1'b1);             // reset mid data handshake

    // 17 retires from reset: counter wraps through zero
    do_reset();
    for (int i = 0; i < 17; i++) step(3'd0, 0, 0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      c  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      fd = ($urandom_range(0, 29) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      dd = ($urandom_range(0, 29) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      step(c, fd, dd, 1'($urandom), $urandom & 32'hffff_fffc,
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
